// File: rtl/dly_cal_pkg.sv
// Shared types and helpers for the delay-line calibration controller.
//   state_e : FSM state encoding
//   clog2   : ceil(log2(v)) for sizing counters (constant-evaluable)
package dly_cal_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    DECIDE = 3'd3,
    TRACK  = 3'd4
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dly_sync2.sv
// Two-flop synchronizer for the asynchronous phase-detector output.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (both flops clear to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output (2-cycle latency)
module dly_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dly_cal_ctrl.sv
// Calibration controller for the tapped inverter delay line.
// Runs a SAR search on the tap code using an averaged phase-detector vote,
// then optionally tracks drift by +/-1 LSB per decision window.
//   clk_i      : clock, all state on rising edge
//   rst_ni     : asynchronous active-low reset
//   start_i    : 1-cycle pulse, begin (re)calibration (ignored while busy)
//   track_en_i : keep tracking +/-1 after lock
//   pd_early_i : async PD output, 1 = delay too short (raise code)
//   sel_o      : tap select to the delay-line mux
//   busy_o     : search in progress
//   locked_o   : search done, sel_o valid
//   err_o      : sticky, tracking tried to step past code 0 or max
module dly_cal_ctrl
  import dly_cal_pkg::*;
#(
  parameter int TAP_W      = 6,
  parameter int SETTLE_CYC = 4,
  parameter int AVG_N      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             track_en_i,
  input  logic             pd_early_i,
  output logic [TAP_W-1:0] sel_o,
  output logic             busy_o,
  output logic             locked_o,
  output logic             err_o
);

  localparam int CNT_MAX = (SETTLE_CYC > AVG_N) ? SETTLE_CYC : AVG_N;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int ONES_W  = clog2(AVG_N) + 1;
  localparam int PTR_W   = (clog2(TAP_W) < 1) ? 1 : clog2(TAP_W);

  localparam logic [CNT_W-1:0]  SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SMP_LAST = CNT_W'(AVG_N - 1);
  localparam logic [ONES_W-1:0] HALF     = ONES_W'(AVG_N / 2);
  localparam logic [PTR_W-1:0]  PTR_TOP  = PTR_W'(TAP_W - 1);
  localparam logic [TAP_W-1:0]  SEL_MAX  = '1;

  logic pd_s;

  dly_sync2 u_pd_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pd_early_i),
    .q_o    (pd_s)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [TAP_W-1:0]    sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  // Distinguishes a tracking decision from a search decision; SETTLE/SAMPLE/
  // DECIDE are shared by both loops.
  logic                trk_q, trk_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ones_q   <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      trk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      trk_q    <= trk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    err_d    = err_q;
    trk_d    = trk_q;

    // A start outside an active search restarts from any state, including
    // the tracking loop (busy is low there).
    if (start_i && !busy_q) begin
      sel_d          = '0;
      sel_d[TAP_W-1] = 1'b1;
      ptr_d          = PTR_TOP;
      cnt_d          = '0;
      err_d          = 1'b0;
      locked_d       = 1'b0;
      busy_d         = 1'b1;
      trk_d          = 1'b0;
      state_d        = SETTLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        TRACK: begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == SET_LAST) begin
            cnt_d   = '0;
            ones_d  = '0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          ones_d = ones_q + ONES_W'(pd_s);
          if (cnt_q == SMP_LAST) begin
            cnt_d   = '0;
            state_d = DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DECIDE: begin
          if (!trk_q) begin
            // Strict majority keeps the trial bit; a tie clears it.
            sel_d[ptr_q] = (ones_q > HALF);
            if (ptr_q != '0) begin
              ptr_d               = ptr_q - 1'b1;
              sel_d[ptr_q - 1'b1] = 1'b1;
              state_d             = SETTLE;
            end else begin
              busy_d   = 1'b0;
              locked_d = 1'b1;
              if (track_en_i) begin
                trk_d   = 1'b1;
                state_d = TRACK;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            // Saturating step: a move past either end is dropped and flagged.
            if (ones_q > HALF) begin
              if (sel_q == SEL_MAX) err_d = 1'b1;
              else                  sel_d = sel_q + 1'b1;
            end else if (ones_q < HALF) begin
              if (sel_q == '0) err_d = 1'b1;
              else             sel_d = sel_q - 1'b1;
            end
            if (track_en_i) begin
              state_d = SETTLE;
            end else begin
              trk_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sel_o    = sel_q;
  assign busy_o   = busy_q;
  assign locked_o = locked_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dly_cal_ctrl.sv
module tb_dly_cal_ctrl;

  localparam int TAP_W      = 6;
  localparam int SETTLE_CYC = 4;
  localparam int AVG_N      = 8;
  localparam int LOCK_CYC   = TAP_W * (SETTLE_CYC + AVG_N + 1);  // 78
  localparam int WIN_CYC    = SETTLE_CYC + AVG_N + 1;            // 13

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             track_en = 1'b0;
  logic             pd;
  logic [TAP_W-1:0] sel;
  logic             busy, locked, err;

  int vecs = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // PD model: THR reads early while sel < thr, so the search settles on thr-1.
  typedef enum {PD_THR, PD_ONE, PD_ZERO, PD_TOG} pdm_e;
  pdm_e mode = PD_THR;
  int   thr  = 38;
  logic tog  = 1'b0;

  always @(posedge clk) tog <= ~tog;

  always_comb begin
    pd = 1'b0;
    case (mode)
      PD_THR:  pd = (int'(sel) < thr);
      PD_ONE:  pd = 1'b1;
      PD_ZERO: pd = 1'b0;
      PD_TOG:  pd = tog;
      default: pd = 1'b0;
    endcase
  end

  dly_cal_ctrl #(.TAP_W(TAP_W), .SETTLE_CYC(SETTLE_CYC), .AVG_N(AVG_N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .track_en_i (track_en),
    .pd_early_i (pd),
    .sel_o      (sel),
    .busy_o     (busy),
    .locked_o   (locked),
    .err_o      (err)
  );

  typedef struct {
    string            tag;
    logic [TAP_W-1:0] sel;
    logic             err;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse START, expect lock LOCK_CYC cycles after BUSY rises. A second START
  // is pulsed n==again cycles into the search (-1: none) and must be ignored.
  task automatic run_search(input string tag, input logic [TAP_W-1:0] esel, input int again);
    exp_t e;
    int   n;
    e.tag = tag; e.sel = esel; e.err = 1'b0;
    sb.push_back(e);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_lock0"}, locked, 0);
    n = 0;
    while (!locked && n < 200) begin
      start = (n == again);
      tick;
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, LOCK_CYC);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_sel"}, sel, e.sel);
      chk({e.tag, "_err"}, err, e.err);
    end
    chk({tag, "_busy0"}, busy, 0);
  endtask

  task automatic wait_err(input string tag, input logic [TAP_W-1:0] esel);
    int n;
    n = 0;
    while (!err && n < 60) begin
      tick;
      n++;
    end
    chk({tag, "_errlat"}, n, WIN_CYC + 1);
    chk({tag, "_err1"}, err, 1);
    chk({tag, "_selhold"}, sel, esel);
    chk({tag, "_locked"}, locked, 1);
  endtask

  initial begin
    int seq[5];
    int prev;
    int n;
    seq = '{38, 39, 40, 39, 40};

    // Reset state
    #2;
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // 1: plain search, land on 37, then hold in IDLE
    mode = PD_THR; thr = 38; track_en = 1'b0;
    run_search("srch37", 6'd37, -1);
    repeat (20) tick;
    chk("idle_sel", sel, 37);
    chk("idle_locked", locked, 1);

    // 6a: START mid-search is ignored
    run_search("again", 6'd37, 20);

    // 2: PD stuck early -> 63, tracking saturates high
    mode = PD_ONE; track_en = 1'b1;
    run_search("one", 6'd63, -1);
    wait_err("one", 6'd63);

    // 3: PD stuck late -> 0, tracking saturates low
    mode = PD_ZERO;
    run_search("zero", 6'd0, -1);
    wait_err("zero", 6'd0);

    // 4: lock at 37, move target, walk up one step per window then dither
    mode = PD_THR; thr = 38;
    run_search("trk", 6'd37, -1);
    thr = 40;
    prev = int'(sel);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (int'(sel) == prev && n < 40) begin
        tick;
        n++;
      end
      chk($sformatf("trk_step%0d", k), sel, seq[k]);
      chk($sformatf("trk_gap%0d", k), n, (k == 0) ? WIN_CYC + 1 : WIN_CYC);
      chk($sformatf("trk_err%0d", k), err, 0);
      prev = int'(sel);
    end

    // 5: tie in every window -> all bits clear, tracking never moves
    mode = PD_TOG;
    run_search("tie", 6'd0, -1);
    for (int k = 0; k < 3; k++) begin
      repeat (WIN_CYC) tick;
      chk($sformatf("tie_sel%0d", k), sel, 0);
      chk($sformatf("tie_err%0d", k), err, 0);
    end

    // 6b: async reset mid-search, then a full fresh search
    mode = PD_THR; thr = 38; track_en = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_locked", locked, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", busy, 0);
    run_search("after_rst", 6'd37, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
